// File: rtl/md_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master drives requests and flush; the slave returns handshake status and HI/LO.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output req_valid, req_op, src1, src2, flush,
      input  req_ready, busy, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, src1, src2, flush,
      output req_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, fixed-latency multiply,
// radix-2 restoring divide, multiply-accumulate/subtract and flush cancellation.
module md_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 1
) (
   input logic        clk,
   input logic        reset,
   md_unit_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CW      = $clog2(CNT_MAX) + 1;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   state_t               r_state;
   state_t               w_next;
   logic [2:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_dvs;
   logic                 r_qneg;
   logic                 r_rneg;
   logic                 r_dz;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_done;

   logic                 w_accept;
   logic                 w_mt_wr;
   logic                 w_mul_wr;
   logic                 w_fix_wr;
   logic                 w_sdiv;
   logic                 w_s1_neg;
   logic                 w_s2_neg;
   logic [WIDTH-1:0]     w_mag1;
   logic [WIDTH-1:0]     w_mag2;
   logic                 w_mul_signed;
   logic [2*WIDTH-1:0]   w_mul_a;
   logic [2*WIDTH-1:0]   w_mul_b;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2*WIDTH-1:0]   w_mul_res;
   logic [WIDTH:0]       w_trial;
   logic                 w_qbit;
   logic [WIDTH-1:0]     w_div_hi;
   logic [WIDTH-1:0]     w_div_lo;

   assign w_accept = bus.req_valid && (r_state == S_IDLE) && !bus.flush;

   always_comb begin
      w_next   = r_state;
      w_mt_wr  = 1'b0;
      w_mul_wr = 1'b0;
      w_fix_wr = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (bus.req_op)
                  OP_MTHI, OP_MTLO: w_mt_wr = 1'b1;
                  OP_DIV, OP_DIVU:  w_next  = S_DIV;
                  default:          w_next  = S_MUL;
               endcase
            end
         end
         S_MUL: begin
            if (bus.flush) begin
               w_next = S_IDLE;
            end else if (r_cnt == MUL_LAST) begin
               w_next   = S_IDLE;
               w_mul_wr = 1'b1;
            end
         end
         S_DIV: begin
            if (bus.flush) begin
               w_next = S_IDLE;
            end else if (r_cnt == DIV_LAST) begin
               w_next = S_FIX;
            end
         end
         S_FIX: begin
            w_next   = S_IDLE;
            w_fix_wr = !bus.flush;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Divider works on magnitudes; signs are reapplied in FIX.
   assign w_sdiv   = (bus.req_op == OP_DIV);
   assign w_s1_neg = w_sdiv && bus.src1[WIDTH-1];
   assign w_s2_neg = w_sdiv && bus.src2[WIDTH-1];
   assign w_mag1   = w_s1_neg ? -bus.src1 : bus.src1;
   assign w_mag2   = w_s2_neg ? -bus.src2 : bus.src2;

   assign w_mul_signed = (r_op != OP_MULTU);
   assign w_mul_a      = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
   assign w_mul_b      = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
   assign w_prod       = w_mul_a * w_mul_b;

   always_comb begin
      case (r_op)
         OP_MADD: w_mul_res = {r_hi, r_lo} + w_prod;
         OP_MSUB: w_mul_res = {r_hi, r_lo} - w_prod;
         default: w_mul_res = w_prod;
      endcase
   end

   // r_quo shifts the dividend out at the top while quotient bits enter at the bottom.
   assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
   assign w_qbit   = !w_trial[WIDTH];
   assign w_div_lo = r_dz ? '1  : (r_qneg ? -r_quo : r_quo);
   assign w_div_hi = r_dz ? r_a : (r_rneg ? -r_rem : r_rem);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dvs   <= '0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_dz    <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_mt_wr | w_mul_wr | w_fix_wr;
         if (w_accept) begin
            r_op   <= bus.req_op;
            r_a    <= bus.src1;
            r_b    <= bus.src2;
            r_cnt  <= '0;
            r_quo  <= w_mag1;
            r_rem  <= '0;
            r_dvs  <= w_mag2;
            r_qneg <= w_s1_neg ^ w_s2_neg;
            r_rneg <= w_s1_neg;
            r_dz   <= (bus.src2 == '0);
         end
         if (w_mt_wr) begin
            if (bus.req_op == OP_MTHI) r_hi <= bus.src1;
            else                       r_lo <= bus.src1;
         end
         if (r_state == S_MUL) r_cnt <= r_cnt + CW'(1);
         if (r_state == S_DIV) begin
            r_cnt <= r_cnt + CW'(1);
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
            r_rem <= w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
         end
         if (w_mul_wr) {r_hi, r_lo} <= w_mul_res;
         if (w_fix_wr) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
         end
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases on a 32-bit/1-cycle-multiply instance and a
// randomized sweep with flushes on an 8-bit/3-cycle-multiply instance against a model.
module tb_md_unit;

   typedef longint unsigned u64_t;

   logic clk = 1'b0;
   logic rst32 = 1'b1;
   logic rst8  = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   md_unit_if #(.WIDTH(32)) bus32 ();
   md_unit_if #(.WIDTH(8))  bus8 ();

   md_unit #(.WIDTH(32), .MUL_LAT(1)) u_dut32 (.clk(clk), .reset(rst32), .bus(bus32));
   md_unit #(.WIDTH(8),  .MUL_LAT(3)) u_dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int latency(input logic [2:0] op, input int w, input int ml);
      if (op == 3'd4 || op == 3'd5) return 0;
      if (op == 3'd2 || op == 3'd3) return w + 1;
      return ml;
   endfunction

   function automatic longint sx(input u64_t v, input int w);
      longint r = longint'(v);
      if (((v >> (w - 1)) & 64'd1) != 0) r = r - (longint'(1) << w);
      return r;
   endfunction

   // Architectural effect of one completed operation on {hi,lo}.
   function automatic void ref_op(input int w, input logic [2:0] op, input u64_t a, input u64_t b,
                                  inout u64_t hi, inout u64_t lo);
      u64_t m  = (u64_t'(1) << w) - 1;
      u64_t m2 = (w >= 32) ? '1 : ((u64_t'(1) << (2 * w)) - 1);
      u64_t p;
      u64_t acc;
      case (op)
         3'd4: hi = a;
         3'd5: lo = a;
         3'd2, 3'd3: begin
            if (b == 0) begin
               lo = m;
               hi = a;
            end else if (op == 3'd3) begin
               lo = a / b;
               hi = a % b;
            end else begin
               lo = $unsigned(sx(a, w) / sx(b, w)) & m;
               hi = $unsigned(sx(a, w) % sx(b, w)) & m;
            end
         end
         default: begin
            if (op == 3'd1) p = a * b;
            else            p = $unsigned(sx(a, w) * sx(b, w));
            acc = (hi << w) | lo;
            if (op == 3'd6)      acc = acc + p;
            else if (op == 3'd7) acc = acc - p;
            else                 acc = p;
            acc = acc & m2;
            hi  = (acc >> w) & m;
            lo  = acc & m;
         end
      endcase
   endfunction

   // Issues one op on the 32-bit unit; returns in cycle A+lat+1, or A+fl_at+1 when flushed.
   task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int fl_at);
      int lat = latency(op, 32, 1);
      bus32.req_valid = 1'b1;
      bus32.req_op    = op;
      bus32.src1      = a;
      bus32.src2      = b;
      tick;
      bus32.req_valid = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         check("busy32", bus32.busy, 1);
         if (c == fl_at) bus32.flush = 1'b1;
         tick;
         bus32.flush = 1'b0;
         if (c == fl_at) break;
      end
   endtask

   task automatic res32(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edone);
      check({tag, "_done"}, bus32.done, edone);
      check({tag, "_hi"}, bus32.hi, ehi);
      check({tag, "_lo"}, bus32.lo, elo);
      check({tag, "_busy"}, bus32.busy, 0);
      check({tag, "_ready"}, bus32.req_ready, 1);
   endtask

   initial begin
      logic [31:0] hold_hi, hold_lo;
      logic        seen_done;
      u64_t        sh_hi, sh_lo;
      logic [2:0]  op;
      logic [7:0]  a8, b8;
      int          mode, lat, fl;
      bit          flushed;

      bus32.req_valid = 1'b0; bus32.req_op = '0; bus32.src1 = '0; bus32.src2 = '0; bus32.flush = 1'b0;
      bus8.req_valid  = 1'b0; bus8.req_op  = '0; bus8.src1  = '0; bus8.src2  = '0; bus8.flush  = 1'b0;

      tick;
      tick;
      res32("reset32", 32'h0, 32'h0, 1'b0);
      check("reset8_hi", bus8.hi, 0);
      check("reset8_lo", bus8.lo, 0);
      check("reset8_busy", bus8.busy, 0);
      check("reset8_ready", bus8.req_ready, 1);
      check("reset8_done", bus8.done, 0);
      rst32 = 1'b0;
      rst8  = 1'b0;
      tick;

      run32(3'd0, 32'hFFFF_FFFF, 32'h2, 0);
      res32("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      run32(3'd1, 32'hFFFF_FFFF, 32'h2, 0);
      res32("multu", 32'h1, 32'hFFFF_FFFE, 1'b1);
      run32(3'd2, 32'hFFFF_FFF9, 32'h2, 0);
      res32("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      run32(3'd3, 32'd7, 32'd2, 0);
      res32("divu_7_2", 32'd1, 32'd3, 1'b1);
      run32(3'd3, 32'd5, 32'd0, 0);
      res32("divu_by0", 32'd5, 32'hFFFF_FFFF, 1'b1);
      run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      res32("div_min_m1", 32'h0, 32'h8000_0000, 1'b1);
      run32(3'd4, 32'h0, 32'h0, 0);
      res32("mthi", 32'h0, 32'h8000_0000, 1'b1);
      run32(3'd5, 32'hFFFF_FFFF, 32'h0, 0);
      res32("mtlo", 32'h0, 32'hFFFF_FFFF, 1'b1);
      run32(3'd6, 32'd1, 32'd1, 0);
      res32("madd", 32'h1, 32'h0, 1'b1);
      run32(3'd7, 32'd1, 32'd1, 0);
      res32("msub", 32'h0, 32'hFFFF_FFFF, 1'b1);
      tick;

      // DIV flushed at A+10: idle at A+11 and no completion at A+34.
      hold_hi = bus32.hi;
      hold_lo = bus32.lo;
      run32(3'd2, 32'd100, 32'd7, 10);
      res32("flush_div", hold_hi, hold_lo, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 23; i++) begin
         tick;
         seen_done |= bus32.done;
      end
      check("flush_div_late_done", seen_done, 0);

      bus32.req_valid = 1'b1;
      bus32.req_op    = 3'd5;
      bus32.src1      = 32'h1234_5678;
      bus32.flush     = 1'b1;
      tick;
      bus32.req_valid = 1'b0;
      bus32.flush     = 1'b0;
      res32("flush_mtlo", hold_hi, hold_lo, 1'b0);

      run32(3'd3, 32'd9, 32'd4, 33);
      res32("flush_fix", hold_hi, hold_lo, 1'b0);

      bus32.req_valid = 1'b1;
      bus32.req_op    = 3'd3;
      bus32.src1      = 32'd50;
      bus32.src2      = 32'd3;
      tick;
      bus32.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      rst32 = 1'b1;
      tick;
      rst32 = 1'b0;
      res32("reset_mid_div", 32'h0, 32'h0, 1'b0);

      sh_hi = 0;
      sh_lo = 0;
      for (int i = 0; i < 2000; i++) begin
         op   = 3'($urandom_range(0, 7));
         a8   = 8'($urandom);
         b8   = 8'($urandom);
         case ($urandom_range(0, 7))
            0: b8 = 8'h00;
            1: begin a8 = 8'h80; b8 = 8'hFF; end
            default: ;
         endcase
         mode = $urandom_range(0, 9);
         lat  = latency(op, 8, 3);
         bus8.req_valid = 1'b1;
         bus8.req_op    = op;
         bus8.src1      = a8;
         bus8.src2      = b8;
         bus8.flush     = (mode == 0);
         tick;
         bus8.req_valid = 1'b0;
         bus8.flush     = 1'b0;
         if (mode == 0) begin
            check("sw_accflush_done", bus8.done, 0);
            check("sw_accflush_busy", bus8.busy, 0);
            check("sw_accflush_hi", bus8.hi, sh_hi);
            check("sw_accflush_lo", bus8.lo, sh_lo);
            continue;
         end
         fl = (mode == 1 && lat > 0) ? $urandom_range(1, lat) : 0;
         flushed = 1'b0;
         for (int c = 1; c <= lat; c++) begin
            check("sw_busy", bus8.busy, 1);
            check("sw_ready", bus8.req_ready, 0);
            check("sw_done_mid", bus8.done, 0);
            check("sw_hi_mid", bus8.hi, sh_hi);
            check("sw_lo_mid", bus8.lo, sh_lo);
            bus8.req_valid = 1'($urandom_range(0, 1));
            bus8.req_op    = 3'($urandom_range(0, 7));
            bus8.src1      = 8'($urandom);
            bus8.src2      = 8'($urandom);
            if (c == fl) bus8.flush = 1'b1;
            tick;
            bus8.req_valid = 1'b0;
            bus8.flush     = 1'b0;
            if (c == fl) begin
               flushed = 1'b1;
               break;
            end
         end
         if (!flushed) ref_op(8, op, u64_t'(a8), u64_t'(b8), sh_hi, sh_lo);
         check("sw_done", bus8.done, !flushed);
         check("sw_hi", bus8.hi, sh_hi);
         check("sw_lo", bus8.lo, sh_lo);
         check("sw_busy_end", bus8.busy, 0);
         check("sw_ready_end", bus8.req_ready, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the execute stage. It accepts one operation per handshake, multiplies with a configurable fixed latency and divides with an in-house radix-2 restoring divider, so no vendor divider IP is needed. It also supports multiply-accumulate and multiply-subtract. An in-flight operation can be cancelled by the exception flush.

## Interface
Parameters:
- WIDTH, 32: operand and HI/LO width; must be ≥ 4.
- MUL_LAT, 1: multiply busy cycles; must be ≥ 1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals !busy.
- req_op  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO, 110 MADD (signed), 111 MSUB (signed)
- src1  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src2  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  cancel current and incoming operation.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Accept: a request is accepted when req_valid && req_ready && !flush. Operands and op are captured at the accept edge.
- States: IDLE, MUL, DIV, FIX.
- MTHI/MTLO:
  - Written at the accept edge: hi or lo ← src1.
  - State stays IDLE; busy is never raised.
- MULT/MULTU/MADD/MSUB:
  - IDLE→MUL. The unit stays in MUL for MUL_LAT cycles, then returns to IDLE, writing {hi,lo} at the last MUL edge.
  - MULT: signed 2·WIDTH product.
  - MULTU: unsigned 2·WIDTH product.
  - MADD: {hi,lo} + signed product.
  - MSUB: {hi,lo} − signed product.
  - All arithmetic is modulo 2^(2·WIDTH).
- DIV/DIVU:
  - IDLE→DIV. Magnitudes are captured at accept.
  - DIV runs WIDTH iterations, one quotient bit per cycle, counter 0..WIDTH−1. It then goes to FIX for one cycle, which applies signs and writes the result, then returns to IDLE.
  - Result: lo = quotient, hi = remainder.
  - Signed DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (DIV and DIVU): lo = all ones, hi = src1. Latency is unchanged.
  - Signed MIN / −1: lo = MIN, hi = 0.
- Flush:
  - Flush in MUL/DIV/FIX: the next state is IDLE. No HI/LO write and no done pulse, including when flush coincides with the writing edge.
  - Flush in IDLE: the request is not accepted, MTHI/MTLO included.
- Reset: state IDLE; hi = lo = 0; busy = 0, done = 0, req_ready = 1. This applies even mid-operation.
- A request offered while busy is ignored; the requester must hold it until req_ready is high.
- done is registered and is asserted only for non-flushed completions.

## Timing
Let A be the accept cycle.
- MTHI/MTLO: new value visible and done high at A+1.
- Multiply family:
  - busy is high A+1 .. A+MUL_LAT.
  - done is high and the result visible at A+MUL_LAT+1.
- Divide:
  - busy is high A+1 .. A+WIDTH+1 (WIDTH DIV cycles plus one FIX cycle).
  - done is high at A+WIDTH+2. For WIDTH=32 this is A+34.
- Back-to-back: req_ready is high in the done cycle, so a new request can be accepted there; throughput is one op per latency.
- hi/lo never change except at the defined write edges.
- The outputs req_ready, busy, done, hi and lo are registered or derived only from state.

## Test plan
All cases use WIDTH=32, MUL_LAT=1 unless stated.
- MULT 0xFFFFFFFF × 0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, done at A+2. MULTU on the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. busy is high A+1..A+33, done at A+34. DIVU 7/2 → lo=3, hi=1.
- Boundary cases:
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADD 1×1 → hi=1, lo=0. MSUB 1×1 afterwards → hi=0, lo=0xFFFFFFFF.
- Flush:
  - Setup: DIV started, flush at A+10.
  - Expected: no done, hi/lo unchanged, req_ready=1 at A+11.
  - Flush asserted with a MTLO request → lo unchanged.
  - Flush in the FIX cycle → no write.
- Reset asserted at A+5 of a DIVU → hi=lo=0, busy=0 the next cycle.
- Sweep with WIDTH=8, MUL_LAT=3 against a reference model: 2000 random ops with random flushes. Multiply done at A+4, divide done at A+10.
